mips_harvard_avalon_bridge: RTL and testbench
=============================================

# mips_harvard_avalon_bridge

Memory-side adapter placed directly downstream of `mips_cpu_harvard`. It serves the core's combinational instruction and data ports from one shared Avalon-MM master port that uses `waitrequest`. Each core step runs the bus transfers in sequence, latches the returned words, then releases the core with a one-cycle `clk_enable` pulse. The Harvard core can therefore run against the same wait-stated memory models as the bus CPU.

## Interface
Parameters:
- `WAIT_LIMIT`, 1024: maximum consecutive `waitrequest`-high cycles on one transfer before a bus error is declared.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `core_active`  in  1  core `active` output.
- `instr_address`  in  32  core PC.
- `instr_readdata`  out  32  latched instruction word, to core.
- `data_address`  in  32  core data address.
- `data_read`  in  1  core load request.
- `data_write`  in  1  core store request.
- `data_writedata`  in  32  core store data.
- `data_readdata`  out  32  latched load word, to core.
- `clk_enable`  out  1  one-cycle step strobe, to core.
- `avm_address`  out  32  word-aligned bus address.
- `avm_read`  out  1  bus read.
- `avm_write`  out  1  bus write.
- `avm_writedata`  out  32  bus write data.
- `avm_byteenable`  out  4  always `4'b1111`.
- `avm_readdata`  in  32  bus read data, valid in the cycle `waitrequest` is low.
- `avm_waitrequest`  in  1  slave stall.
- `halted`  out  1  sticky: core finished.
- `bus_error`  out  1  sticky: watchdog expired.

## Operation
- States: FETCH, ACCESS, COMMIT, HALT, ERROR.
- Reset values:
  - state = FETCH.
  - `instr_readdata`, `data_readdata` = 0.
  - `clk_enable`, `avm_read`, `avm_write`, `halted`, `bus_error` = 0.
  - wait counter = 0.
- FETCH:
  - If `core_active` = 0: no bus request; next state HALT.
  - Otherwise: `avm_read` = 1, `avm_address` = `{instr_address[31:2],2'b00}`.
  - On `waitrequest` = 0: latch `avm_readdata` into `instr_readdata`.
  - Next state is ACCESS if the core, decoding the new word, asserts `data_read` or `data_write` on the following cycle. Otherwise it is COMMIT.
  - The next state is selected in the cycle after the latch, evaluated from ACCESS entry; ACCESS with no request falls through to COMMIT.
- ACCESS:
  - `avm_address` = `{data_address[31:2],2'b00}`.
  - `data_write` = 1: `avm_write` = 1, `avm_writedata` = `data_writedata`. Write has priority if `data_read` and `data_write` are both high.
  - Else `data_read` = 1: `avm_read` = 1. On completion, latch `avm_readdata` into `data_readdata`.
  - Neither request: no bus op; next state COMMIT.
  - Leave ACCESS only on completion (`waitrequest` = 0).
- COMMIT: `clk_enable` = 1 for exactly this cycle; next state FETCH.
- HALT: absorbing. `halted` = 1; no bus activity; `clk_enable` = 0.
- ERROR: absorbing. `bus_error` = 1; drop the request; `clk_enable` = 0.
- Watchdog:
  - Counter increments each cycle a request is held with `waitrequest` = 1.
  - Clears on completion and on every state change.
  - Reaching `WAIT_LIMIT` sends the state to ERROR.
- `avm_read`/`avm_write` are combinational from state and inputs. They are never both high.
- `reset` in any state aborts an in-flight transfer at the next edge; the slave is reset alongside. Only `reset` exits HALT and ERROR.

## Timing
- Zero-wait latencies:
  - Non-memory instruction: FETCH 1 + ACCESS 1 + COMMIT 1 = 3 cycles per step.
  - Load/store: 3 cycles per step, plus N cycles per transfer with N wait cycles.
- `instr_readdata` and `data_readdata` hold stable from their latch through the COMMIT edge. The core therefore sees steady combinational inputs at its enabled edge.
- Core outputs (`instr_address`, `data_*`) must be stable while `clk_enable` = 0. The bridge samples them without registering.
- First bus request appears in the first cycle after `reset` deasserts.

## Structure
- Package `mips_bridge_pkg`: `bridge_state_t` enum, `WAIT_LIMIT_DEFAULT` constant, `BYTEENABLE_WORD = 4'b1111`.
- One sub-module, `bus_wait_watchdog`: a counter with `clear`, `count_en` and `expired` outputs, parameterised by `WAIT_LIMIT`.

## Test plan
- **Zero-wait fetch, non-memory instruction.** After reset, memory at 0xBFC00000 holds 0x24020005 → `avm_read` at 0xBFC00000 in cycle 1; `instr_readdata` = 0x24020005; `clk_enable` pulse in cycle 3; next FETCH in cycle 4.
- **Load with 3 wait cycles.** `data_address` = 0x00001006 → `avm_address` = 0x00001004; `avm_read` held 4 cycles; `data_readdata` = 0xDEADBEEF; one `clk_enable` pulse after completion.
- **Store.** `data_write` = 1, `data_writedata` = 0x12345678, `data_address` = 0x2000 → `avm_write` = 1 exactly one cycle with zero wait; `avm_byteenable` = 0xF; no `avm_read` in ACCESS.
- **Halt.** `core_active` drops after a COMMIT → no further `avm_read`; `halted` = 1 within 1 cycle; `clk_enable` stays 0 for 100 cycles.
- **Watchdog.** `WAIT_LIMIT` = 8 with `waitrequest` stuck high in FETCH → `bus_error` = 1 after 8 cycles; `avm_read` = 0 thereafter.
- **Reset mid-ACCESS.** `reset` pulsed during a stalled load → next cycle `avm_read` = 0, state FETCH, `data_readdata` = 0; fetch restarts at the core reset PC.

Source files
------------

// File: rtl/mips_bridge_pkg.sv
// Shared types and constants for the Harvard-core to Avalon-MM bridge.
// Imported by the bridge top and its wait watchdog.
package mips_bridge_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_ACCESS,
        ST_COMMIT,
        ST_HALT,
        ST_ERROR
    } bridge_state_t;

    localparam int         WAIT_LIMIT_DEFAULT = 1024;
    localparam logic [3:0] BYTEENABLE_WORD    = 4'b1111;

    // The bus is word-addressed; byte offsets from the core are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/bus_wait_watchdog.sv
// Counts consecutive stalled cycles of one bus transfer and flags the cycle
// in which the stall budget runs out.
module bus_wait_watchdog
    import mips_bridge_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the WAIT_LIMIT-th stalled cycle so the owner can leave at that edge.
    assign expired = count_en && (count_q == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/mips_harvard_avalon_bridge.sv
// Serialises the Harvard core's instruction and data ports onto one Avalon-MM
// master, then steps the core once per instruction with a clk_enable pulse.
module mips_harvard_avalon_bridge
    import mips_bridge_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        halted,
    output logic        bus_error
);

    bridge_state_t state_q, state_d;
    logic [31:0]   instr_readdata_q, instr_readdata_d;
    logic [31:0]   data_readdata_q, data_readdata_d;

    logic req_read;
    logic req_write;
    logic req_done;
    logic wd_clear;
    logic wd_count_en;
    logic wd_expired;

    // Requests are suppressed while reset is high so an in-flight transfer is
    // abandoned immediately rather than completing against a resetting slave.
    always_comb begin
        req_read    = 1'b0;
        req_write   = 1'b0;
        avm_address = '0;
        if (!reset) begin
            unique case (state_q)
                ST_FETCH: begin
                    if (core_active) begin
                        req_read    = 1'b1;
                        avm_address = word_align(instr_address);
                    end
                end
                ST_ACCESS: begin
                    avm_address = word_align(data_address);
                    if (data_write) begin
                        req_write = 1'b1;
                    end else if (data_read) begin
                        req_read = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_done = (req_read || req_write) && !avm_waitrequest;

    always_comb begin
        state_d          = state_q;
        instr_readdata_d = instr_readdata_q;
        data_readdata_d  = data_readdata_q;
        unique case (state_q)
            ST_FETCH: begin
                if (!core_active) begin
                    state_d = ST_HALT;
                end else if (req_done) begin
                    instr_readdata_d = avm_readdata;
                    state_d          = ST_ACCESS;
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ACCESS: begin
                // The core decodes the freshly latched word here, so an empty
                // request is only known once ACCESS is entered.
                if (!req_read && !req_write) begin
                    state_d = ST_COMMIT;
                end else if (req_done) begin
                    if (req_read) begin
                        data_readdata_d = avm_readdata;
                    end
                    state_d = ST_COMMIT;
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_COMMIT: state_d = ST_FETCH;
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_FETCH;
            instr_readdata_q <= '0;
            data_readdata_q  <= '0;
        end else begin
            state_q          <= state_d;
            instr_readdata_q <= instr_readdata_d;
            data_readdata_q  <= data_readdata_d;
        end
    end

    assign wd_count_en = (req_read || req_write) && avm_waitrequest;
    assign wd_clear    = req_done || (state_d != state_q);

    bus_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    assign avm_read       = req_read;
    assign avm_write      = req_write;
    assign avm_writedata  = data_writedata;
    assign avm_byteenable = BYTEENABLE_WORD;
    assign instr_readdata = instr_readdata_q;
    assign data_readdata  = data_readdata_q;
    assign clk_enable     = (state_q == ST_COMMIT);
    assign halted         = (state_q == ST_HALT);
    assign bus_error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_mips_harvard_avalon_bridge.sv
// Drives the bridge with a toy in-order core and a wait-stated memory slave,
// checking each step against a transaction-level model of the program.
`timescale 1ns/1ps
module tb_mips_harvard_avalon_bridge;

    localparam int          WL       = 8;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] WKEY     = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_active;
    logic [31:0] instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write, clk_enable;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic        halted, bus_error;

    always #5 clk = ~clk;

    mips_harvard_avalon_bridge #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .core_active(core_active),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .clk_enable(clk_enable), .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .halted(halted), .bus_error(bus_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    int          wait_q[$];
    txn_t        txn_log[$];
    int          wait_left;
    bit          in_xfer;
    bit          stuck;

    logic [31:0] core_pc;
    bit          wforce;
    logic [31:0] wforce_val;

    logic        obs_read, obs_write, obs_ce, obs_halted, obs_err;
    logic [31:0] obs_addr, obs_wdata, obs_ird, obs_drd;
    logic [3:0]  obs_be;
    int          overlap_cnt, be_bad_cnt;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Toy core: lw = 0x23, sw = 0x2B, 0x3F raises both requests; address from imm16.
    task automatic core_drive();
        logic [5:0] op;
        op             = instr_readdata[31:26];
        instr_address  = core_pc;
        data_read      = (op == 6'h23) || (op == 6'h3F);
        data_write     = (op == 6'h2B) || (op == 6'h3F);
        data_address   = {16'h0000, instr_readdata[15:0]};
        data_writedata = wforce ? wforce_val : (instr_readdata ^ WKEY);
    endtask

    // One clock: observe and serve the bus at negedge, advance the core after posedge.
    task automatic cycle();
        @(negedge clk);
        obs_read = avm_read;     obs_write = avm_write;   obs_addr = avm_address;
        obs_wdata = avm_writedata; obs_be = avm_byteenable; obs_ce = clk_enable;
        obs_ird = instr_readdata; obs_drd = data_readdata;
        obs_halted = halted;     obs_err = bus_error;
        if (avm_read && avm_write) overlap_cnt++;
        if ((avm_read || avm_write) && avm_byteenable != 4'hF) be_bad_cnt++;
        if (avm_read || avm_write) begin
            if (!in_xfer) begin
                in_xfer   = 1'b1;
                wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            end
            if (stuck || wait_left > 0) begin
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                if (wait_left > 0) wait_left--;
            end else begin
                avm_waitrequest = 1'b0;
                in_xfer         = 1'b0;
                if (avm_write) begin
                    slave_mem[avm_address] = avm_writedata;
                    txn_log.push_back('{1'b1, avm_address, avm_writedata});
                end else begin
                    avm_readdata = slave_rd(avm_address);
                    txn_log.push_back('{1'b0, avm_address, avm_readdata});
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
            in_xfer         = 1'b0;
            avm_readdata    = $urandom;
        end
        @(posedge clk);
        #1;
        if (reset) core_pc = RESET_PC;
        else if (obs_ce) core_pc = core_pc + 32'd4;
        core_drive();
    endtask

    task automatic reset_dut();
        reset = 1'b1; stuck = 1'b0; wforce = 1'b0; core_active = 1'b1;
        wait_q.delete(); txn_log.delete(); in_xfer = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        slave_mem.delete();
        reset = 1'b1;
        cycle();
        cycle();
        n_checks++; if (obs_read !== 1'b0 || obs_write !== 1'b0) begin n_fail++; $display("FAIL reset_req: rd=%b wr=%b expected 0/0", obs_read, obs_write); end
        n_checks++; if (obs_ce !== 1'b0) begin n_fail++; $display("FAIL reset_clk_enable: got %b expected 0", obs_ce); end
        n_checks++; if (obs_halted !== 1'b0 || obs_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: halted=%b bus_error=%b expected 0/0", obs_halted, obs_err); end
        n_checks++; if (obs_ird !== 32'h0 || obs_drd !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: instr=%h data=%h expected 0/0", obs_ird, obs_drd); end
        reset = 1'b0;
        cycle();
        n_checks++; if (obs_read !== 1'b1 || obs_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_first_fetch: rd=%b addr=%h expected 1 @%h", obs_read, obs_addr, RESET_PC); end
    endtask

    task automatic test_fetch_nonmem();
        slave_mem.delete();
        slave_mem[RESET_PC] = 32'h2402_0005;
        reset_dut();
        cycle();
        n_checks++; if (obs_read !== 1'b1 || obs_addr !== RESET_PC || obs_ce !== 1'b0) begin n_fail++; $display("FAIL fetch_c1: rd=%b addr=%h ce=%b expected 1 %h 0", obs_read, obs_addr, obs_ce, RESET_PC); end
        cycle();
        n_checks++; if (obs_ird !== 32'h2402_0005) begin n_fail++; $display("FAIL fetch_instr: got %h expected 24020005", obs_ird); end
        n_checks++; if (obs_read !== 1'b0 || obs_write !== 1'b0 || obs_ce !== 1'b0) begin n_fail++; $display("FAIL fetch_c2_idle: rd=%b wr=%b ce=%b expected 0 0 0", obs_read, obs_write, obs_ce); end
        cycle();
        n_checks++; if (obs_ce !== 1'b1) begin n_fail++; $display("FAIL fetch_c3_commit: ce=%b expected 1", obs_ce); end
        cycle();
        n_checks++; if (obs_ce !== 1'b0 || obs_read !== 1'b1 || obs_addr !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL fetch_c4_next: ce=%b rd=%b addr=%h expected 0 1 %h", obs_ce, obs_read, obs_addr, RESET_PC + 32'd4); end
    endtask

    task automatic test_load_wait3();
        int rd_cyc, ce_cnt, ce_at;
        logic [31:0] ce_drd;
        slave_mem.delete();
        slave_mem[RESET_PC]    = 32'h8C00_1006;
        slave_mem[32'h0000_1004] = 32'hDEAD_BEEF;
        reset_dut();
        wait_q = '{0, 3};
        rd_cyc = 0; ce_cnt = 0; ce_at = 0; ce_drd = 32'h0;
        cycle();
        for (int c = 2; c <= 6; c++) begin
            cycle();
            if (obs_read && obs_addr == 32'h0000_1004) rd_cyc++;
            if (obs_ce) begin ce_cnt++; ce_at = c; ce_drd = obs_drd; end
        end
        n_checks++; if (rd_cyc != 4) begin n_fail++; $display("FAIL load_read_cycles: got %0d expected 4", rd_cyc); end
        n_checks++; if (ce_cnt != 1 || ce_at != 6) begin n_fail++; $display("FAIL load_commit: pulses=%0d at cycle %0d expected 1 at 6", ce_cnt, ce_at); end
        n_checks++; if (ce_drd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data: got %h expected deadbeef", ce_drd); end
    endtask

    task automatic test_store();
        slave_mem.delete();
        slave_mem[RESET_PC] = 32'hAC00_2000;
        reset_dut();
        wforce = 1'b1; wforce_val = 32'h1234_5678;
        wait_q = '{0, 0};
        cycle();
        cycle();
        n_checks++; if (obs_write !== 1'b1 || obs_read !== 1'b0 || obs_addr !== 32'h2000) begin n_fail++; $display("FAIL store_req: wr=%b rd=%b addr=%h expected 1 0 00002000", obs_write, obs_read, obs_addr); end
        n_checks++; if (obs_wdata !== 32'h1234_5678 || obs_be !== 4'hF) begin n_fail++; $display("FAIL store_data: data=%h be=%h expected 12345678 f", obs_wdata, obs_be); end
        cycle();
        n_checks++; if (obs_write !== 1'b0 || obs_ce !== 1'b1) begin n_fail++; $display("FAIL store_commit: wr=%b ce=%b expected 0 1", obs_write, obs_ce); end
        n_checks++; if (slave_rd(32'h2000) !== 32'h1234_5678) begin n_fail++; $display("FAIL store_mem: got %h expected 12345678", slave_rd(32'h2000)); end
        wforce = 1'b0;
    endtask

    task automatic test_halt();
        int guard, reqs, ces, not_halted;
        slave_mem.delete();
        slave_mem[RESET_PC] = 32'h2402_0005;
        reset_dut();
        guard = 0;
        do begin cycle(); guard++; end while (!obs_ce && guard < 20);
        n_checks++; if (obs_ce !== 1'b1) begin n_fail++; $display("FAIL halt_first_commit: no clk_enable within %0d cycles", guard); end
        core_active = 1'b0;
        cycle();
        n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL halt_no_fetch: rd=%b expected 0", obs_read); end
        cycle();
        n_checks++; if (obs_halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b expected 1", obs_halted); end
        reqs = 0; ces = 0; not_halted = 0;
        for (int c = 0; c < 100; c++) begin
            if (c == 50) core_active = 1'b1;
            cycle();
            if (obs_read || obs_write) reqs++;
            if (obs_ce) ces++;
            if (!obs_halted) not_halted++;
        end
        n_checks++; if (reqs != 0 || ces != 0) begin n_fail++; $display("FAIL halt_quiet: req cycles=%0d ce pulses=%0d expected 0 0", reqs, ces); end
        n_checks++; if (not_halted != 0) begin n_fail++; $display("FAIL halt_sticky: halted low %0d cycles expected 0", not_halted); end
    endtask

    task automatic test_watchdog();
        int rd_cyc, late_rd, late_bad;
        bit seen;
        slave_mem.delete();
        reset_dut();
        stuck = 1'b1;
        rd_cyc = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cycle();
            if (obs_err) seen = 1'b1;
            else if (obs_read) rd_cyc++;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL wd_timeout: bus_error never rose within 40 cycles"); end
        n_checks++; if (rd_cyc != WL) begin n_fail++; $display("FAIL wd_limit: stalled read cycles=%0d expected %0d", rd_cyc, WL); end
        late_rd = 0; late_bad = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (obs_read || obs_write) late_rd++;
            if (!obs_err || obs_ce) late_bad++;
        end
        n_checks++; if (late_rd != 0 || late_bad != 0) begin n_fail++; $display("FAIL wd_absorb: req cycles=%0d flag/ce faults=%0d expected 0 0", late_rd, late_bad); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        slave_mem.delete();
        slave_mem[RESET_PC]            = 32'h8C00_1006;
        slave_mem[RESET_PC + 32'd4]    = 32'h8C00_1006;
        slave_mem[32'h0000_1004]       = 32'hDEAD_BEEF;
        reset_dut();
        wait_q = '{0, 0, 0, 6};
        cycle(); cycle(); cycle();
        n_checks++; if (obs_ce !== 1'b1 || obs_drd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_pre_load: ce=%b data=%h expected 1 deadbeef", obs_ce, obs_drd); end
        cycle(); cycle(); cycle();
        n_checks++; if (obs_read !== 1'b1 || obs_addr !== 32'h1004) begin n_fail++; $display("FAIL rst_stalled_load: rd=%b addr=%h expected 1 00001004", obs_read, obs_addr); end
        reset = 1'b1;
        cycle();
        n_checks++; if (obs_read !== 1'b0) begin n_fail++; $display("FAIL rst_abort: rd=%b expected 0", obs_read); end
        reset = 1'b0;
        wait_q.delete();
        cycle();
        n_checks++; if (obs_drd !== 32'h0 || obs_ird !== 32'h0) begin n_fail++; $display("FAIL rst_readdata: data=%h instr=%h expected 0 0", obs_drd, obs_ird); end
        n_checks++; if (obs_read !== 1'b1 || obs_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_refetch: rd=%b addr=%h expected 1 %h", obs_read, obs_addr, RESET_PC); end
    endtask

    task automatic test_random_steps();
        localparam int NSTEP = 40;
        logic [31:0] pc, w, daddr, exp_drd;
        logic [5:0]  op;
        bit          is_mem, wr, rd, ce_seen;
        int          wf, wa, exp_cyc, cyc, mem_bad;
        slave_mem.delete();
        ref_mem.delete();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            slave_mem[32'h1000 + 32'(4 * i)] = w;
            ref_mem[32'h1000 + 32'(4 * i)]   = w;
        end
        for (int i = 0; i < NSTEP; i++) begin
            case ($urandom_range(0, 3))
                0:       w = {6'h09, 26'($urandom)};
                1:       w = {6'h23, 10'($urandom), 16'(16'h1000 + 16'($urandom_range(0, 63)))};
                2:       w = {6'h2B, 10'($urandom), 16'(16'h1000 + 16'($urandom_range(0, 63)))};
                default: w = {6'h3F, 10'($urandom), 16'(16'h1000 + 16'($urandom_range(0, 63)))};
            endcase
            slave_mem[RESET_PC + 32'(4 * i)] = w;
            ref_mem[RESET_PC + 32'(4 * i)]   = w;
        end
        reset_dut();
        overlap_cnt = 0; be_bad_cnt = 0;
        exp_drd = 32'h0;
        for (int s = 0; s < NSTEP; s++) begin
            pc     = RESET_PC + 32'(4 * s);
            w      = ref_rd(pc);
            op     = w[31:26];
            wr     = (op == 6'h2B) || (op == 6'h3F);
            rd     = (op == 6'h23);
            is_mem = wr || rd;
            daddr  = {16'h0000, w[15:2], 2'b00};
            wf     = int'($urandom_range(0, 4));
            wait_q.push_back(wf);
            exp_cyc = 3 + wf;
            if (is_mem) begin
                wa = int'($urandom_range(0, 4));
                wait_q.push_back(wa);
                exp_cyc += wa;
            end
            if (wr) ref_mem[daddr] = w ^ WKEY;
            else if (rd) exp_drd = ref_rd(daddr);
            txn_log.delete();
            cyc = 0; ce_seen = 1'b0;
            while (!ce_seen && cyc < 40) begin
                cycle();
                cyc++;
                ce_seen = obs_ce;
            end
            n_checks++; if (!ce_seen || cyc != exp_cyc) begin n_fail++; $display("FAIL step%0d_cycles: commit seen=%0b after %0d cycles expected %0d", s, ce_seen, cyc, exp_cyc); end
            n_checks++; if (obs_ird !== w || obs_drd !== exp_drd) begin n_fail++; $display("FAIL step%0d_latched: instr=%h data=%h expected %h %h", s, obs_ird, obs_drd, w, exp_drd); end
            n_checks++;
            if (txn_log.size() != (is_mem ? 2 : 1)) begin
                n_fail++; $display("FAIL step%0d_txn_count: got %0d expected %0d", s, txn_log.size(), is_mem ? 2 : 1);
            end else if (txn_log[0].is_write !== 1'b0 || txn_log[0].addr !== pc || txn_log[0].data !== w) begin
                n_fail++; $display("FAIL step%0d_fetch_txn: wr=%b addr=%h data=%h expected 0 %h %h", s, txn_log[0].is_write, txn_log[0].addr, txn_log[0].data, pc, w);
            end else if (is_mem && (txn_log[1].is_write !== wr || txn_log[1].addr !== daddr || txn_log[1].data !== (wr ? (w ^ WKEY) : exp_drd))) begin
                n_fail++; $display("FAIL step%0d_data_txn: wr=%b addr=%h data=%h expected %b %h %h", s, txn_log[1].is_write, txn_log[1].addr, txn_log[1].data, wr, daddr, wr ? (w ^ WKEY) : exp_drd);
            end
            $display("step %0d pc=%h instr=%h cycles=%0d", s, pc, w, cyc);
        end
        n_checks++; if (overlap_cnt != 0 || be_bad_cnt != 0) begin n_fail++; $display("FAIL random_bus_rules: rd&wr cycles=%0d bad byteenable=%0d expected 0 0", overlap_cnt, be_bad_cnt); end
        mem_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (slave_rd(32'h1000 + 32'(4 * i)) !== ref_rd(32'h1000 + 32'(4 * i))) mem_bad++;
        end
        n_checks++; if (mem_bad != 0) begin n_fail++; $display("FAIL random_final_mem: %0d words differ expected 0", mem_bad); end
    endtask

    initial begin
        reset = 1'b1; core_active = 1'b1; core_pc = RESET_PC;
        instr_address = RESET_PC; data_address = '0; data_read = 1'b0; data_write = 1'b0;
        data_writedata = '0; avm_readdata = '0; avm_waitrequest = 1'b0;
        wforce = 1'b0; wforce_val = '0; stuck = 1'b0; in_xfer = 1'b0; wait_left = 0;
        overlap_cnt = 0; be_bad_cnt = 0;
        test_reset();
        test_fetch_nonmem();
        test_load_wait3();
        test_store();
        test_halt();
        test_watchdog();
        test_reset_mid_access();
        test_random_steps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
